mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter sharing the single burst memory port (addr / burst_len / rd / wr / waitrequest / rd_valid) between the instruction-side and data-side generic caches. It grants whole transactions round-robin, holding the grant until every beat of the burst has completed. Each master sees a memory-compatible slave port, so caches connect unchanged, and the memory model connects unchanged to the master side.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- BURSTLEN_WIDTH, 2, burst length field width; beats = burst_len + 1
- clock  input  1  rising-edge clock
- reset  input  1  reset; asynchronous, active-high; all state is cleared immediately on assertion
- mN_addr  input  ADDR_WIDTH  master N address (N = 0 data cache, N = 1 instruction cache)
- mN_burst_len  input  BURSTLEN_WIDTH  master N burst length
- mN_rd / mN_wr  input  1  master N read / write request
- mN_wr_data  input  DATA_WIDTH  master N write beat data
- mN_waitrequest  output  1  stall to master N
- mN_rd_valid  output  1  read beat valid to master N
- mN_rd_data  output  DATA_WIDTH  read beat data to master N
- mem_addr, mem_burst_len, mem_wr_data  output  as above  command to memory
- mem_rd / mem_wr  output  1  memory read / write strobe
- mem_waitrequest  input  1  memory stall
- mem_rd_valid  input  1  memory read beat valid
- mem_rd_data  input  DATA_WIDTH  memory read beat data

## Operation
- Request: reqN = mN_rd | mN_wr. If a master asserts both, the read takes priority and the write remains pending.
- Registers:
  - state: IDLE, RD_CMD, RD_DATA, WR
  - owner: 1 bit
  - last: last granted master; resets to 1, so master 0 wins the first tie
  - beats: BURSTLEN_WIDTH bits
- IDLE: all mN_waitrequest = 1; mem_rd = mem_wr = 0.
  - With one requester, grant it.
  - With both requesting, grant !last.
  - On grant: owner <= winner, last <= winner, beats <= 0.
  - Next state is RD_CMD if the winner's mN_rd is set, otherwise WR.
- RD_CMD: owner's addr, burst_len and rd pass combinationally to memory; owner waitrequest = mem_waitrequest.
  - Accept (mem_rd & !mem_waitrequest): latch burst length into a register blen; go to RD_DATA.
  - Owner drops rd before acceptance: return to IDLE.
- RD_DATA: mem_rd = 0; owner waitrequest = 1.
  - mem_rd_valid / mem_rd_data are routed to the owner only. The non-owner always sees rd_valid = 0 and rd_data = 0.
  - Each valid beat increments beats. The beat with beats == blen returns to IDLE.
- WR: owner's addr, burst_len, wr_data and wr pass to memory; owner waitrequest = mem_waitrequest.
  - blen is latched from mN_burst_len on grant entry.
  - Each accepted beat (mem_wr & !mem_waitrequest) increments beats. The accepted beat with beats == blen returns to IDLE.
  - Owner deasserting wr mid-burst holds the state; the arbiter waits for the remaining beats.
- Non-owner: waitrequest = 1 at all times; its command is never forwarded.
- Outside RD_CMD and WR, mem_addr, mem_burst_len and mem_wr_data are 0.

## Timing
- Reset: state = IDLE, owner = 0, last = 1, beats = 0, blen = 0.
  - Outputs on reset: mN_waitrequest = 1, mN_rd_valid = 0, mN_rd_data = 0, mem_rd = mem_wr = 0, mem_addr / mem_burst_len / mem_wr_data = 0.
- Arbitration latency: a request first seen in IDLE at cycle t is presented to memory in cycle t+1. If memory does not stall, the master's waitrequest drops in cycle t+1.
- Bus turnaround: exactly one IDLE cycle between consecutive transactions. Two masters requesting continuously alternate grants.
- Read data path is combinational: mem_rd_valid → owner rd_valid in the same cycle, zero added latency.
- A burst_len of 0 is a single beat. The maximum burst (all ones) is 2^BURSTLEN_WIDTH beats; the beats counter must not wrap before the compare.
- Memory may return the first rd_valid in the cycle after acceptance or later. rd_valid is ignored in IDLE and RD_CMD; the memory never issues it there.
- A new request arriving during RD_DATA or WR stalls (waitrequest = 1) until the next IDLE.
- Reset mid-burst aborts immediately to the reset values. Any beats in flight at memory are dropped, and the bench resets memory together with the arbiter.

## Test plan
- Master 0 alone reads 0x100 with burst_len 3 from sequential memory → one IDLE cycle, mem_addr = 0x100, m0 receives 0x40, 0x41, 0x42, 0x43 on 4 rd_valid beats; m1_rd_valid stays 0.
- Master 1 alone writes 4 beats 0xA0..0xA3 to 0x200 with memory stalling 2 cycles per beat → m1_waitrequest mirrors mem_waitrequest, memory holds 0xA0..0xA3, state returns to IDLE after the 4th accepted beat.
- Both request in the same cycle after reset → m0 is granted first; m1 is granted in the IDLE cycle following m0's last beat. With both held requesting, grants alternate 0,1,0,1.
- Master 0 asserts rd and wr together → a read is issued; the write issues as a separate transaction afterwards.
- burst_len 0 read, then a burst_len 3 write from the same master → single beat returned, then 4 write beats; no beat lost or duplicated.
- Reset asserted during beat 2 of a 4-beat read → outputs take reset values immediately. A subsequent master 1 read completes correctly.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one burst memory port between the data-side (m0)
// and instruction-side (m1) caches, granting whole bursts at a time.
//   state   | meaning
//   IDLE    | no owner; pick a winner from pending requests
//   RD_CMD  | owner's read command presented to memory
//   RD_DATA | read accepted; route returning beats to owner
//   WR      | owner's write beats forwarded until the burst completes
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BURSTLEN_WIDTH = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     m0_addr,
   input  logic [BURSTLEN_WIDTH-1:0] m0_burst_len,
   input  logic                      m0_rd,
   input  logic                      m0_wr,
   input  logic [DATA_WIDTH-1:0]     m0_wr_data,
   output logic                      m0_waitrequest,
   output logic                      m0_rd_valid,
   output logic [DATA_WIDTH-1:0]     m0_rd_data,
   input  logic [ADDR_WIDTH-1:0]     m1_addr,
   input  logic [BURSTLEN_WIDTH-1:0] m1_burst_len,
   input  logic                      m1_rd,
   input  logic                      m1_wr,
   input  logic [DATA_WIDTH-1:0]     m1_wr_data,
   output logic                      m1_waitrequest,
   output logic                      m1_rd_valid,
   output logic [DATA_WIDTH-1:0]     m1_rd_data,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [BURSTLEN_WIDTH-1:0] mem_burst_len,
   output logic [DATA_WIDTH-1:0]     mem_wr_data,
   output logic                      mem_rd,
   output logic                      mem_wr,
   input  logic                      mem_waitrequest,
   input  logic                      mem_rd_valid,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

   typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR} state_t;

   state_t                    state, state_nxt;
   logic                      owner, owner_nxt;
   logic                      last, last_nxt;
   logic [BURSTLEN_WIDTH-1:0] beats, beats_nxt;
   logic [BURSTLEN_WIDTH-1:0] blen, blen_nxt;

   logic                      req0, req1, win, win_rd;
   logic [BURSTLEN_WIDTH-1:0] win_bl;
   logic [ADDR_WIDTH-1:0]     own_addr;
   logic [BURSTLEN_WIDTH-1:0] own_bl;
   logic [DATA_WIDTH-1:0]     own_wdata;
   logic                      own_rd, own_wr, own_wait, rd_route;

   assign req0      = m0_rd | m0_wr;
   assign req1      = m1_rd | m1_wr;
   // Tie goes to the master that did not win last time.
   assign win       = (req0 & req1) ? ~last : req1;
   assign win_rd    = win ? m1_rd : m0_rd;
   assign win_bl    = win ? m1_burst_len : m0_burst_len;
   assign own_addr  = owner ? m1_addr : m0_addr;
   assign own_bl    = owner ? m1_burst_len : m0_burst_len;
   assign own_wdata = owner ? m1_wr_data : m0_wr_data;
   assign own_rd    = owner ? m1_rd : m0_rd;
   assign own_wr    = owner ? m1_wr : m0_wr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         beats <= '0;
         blen  <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         beats <= beats_nxt;
         blen  <= blen_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      last_nxt      = last;
      beats_nxt     = beats;
      blen_nxt      = blen;
      mem_addr      = '0;
      mem_burst_len = '0;
      mem_wr_data   = '0;
      mem_rd        = 1'b0;
      mem_wr        = 1'b0;
      own_wait      = 1'b1;
      rd_route      = 1'b0;
      case (state)
         IDLE: begin
            if (req0 | req1) begin
               owner_nxt = win;
               last_nxt  = win;
               beats_nxt = '0;
               if (win_rd) begin
                  state_nxt = RD_CMD;
               end else begin
                  state_nxt = WR;
                  blen_nxt  = win_bl;
               end
            end
         end
         RD_CMD: begin
            mem_addr      = own_addr;
            mem_burst_len = own_bl;
            mem_rd        = own_rd;
            own_wait      = mem_waitrequest;
            if (!own_rd) begin
               state_nxt = IDLE;
            end else if (!mem_waitrequest) begin
               blen_nxt  = own_bl;
               state_nxt = RD_DATA;
            end
         end
         RD_DATA: begin
            rd_route = mem_rd_valid;
            if (mem_rd_valid) begin
               if (beats == blen) state_nxt = IDLE;
               else               beats_nxt = beats + BURSTLEN_WIDTH'(1);
            end
         end
         WR: begin
            mem_addr      = own_addr;
            mem_burst_len = own_bl;
            mem_wr_data   = own_wdata;
            mem_wr        = own_wr;
            own_wait      = mem_waitrequest;
            // A master pausing wr mid-burst keeps the grant until all beats land.
            if (own_wr && !mem_waitrequest) begin
               if (beats == blen) state_nxt = IDLE;
               else               beats_nxt = beats + BURSTLEN_WIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign m0_waitrequest = owner ? 1'b1 : own_wait;
   assign m1_waitrequest = owner ? own_wait : 1'b1;
   assign m0_rd_valid    = rd_route & ~owner;
   assign m1_rd_valid    = rd_route & owner;
   assign m0_rd_data     = (rd_route & ~owner) ? mem_rd_data : '0;
   assign m1_rd_data     = (rd_route & owner) ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vector table from reset, then burst sequences
// against a small sequential memory model with configurable stalls.
module tb_mem_arbiter;

   logic        clock, reset;
   logic [31:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data;
   logic [1:0]  m0_burst_len, m1_burst_len;
   logic        m0_rd, m0_wr, m1_rd, m1_wr;
   logic        m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
   logic [1:0]  mem_burst_len;
   logic        mem_rd, mem_wr, mem_waitrequest, mem_rd_valid;

   int n_checks = 0;
   int n_err    = 0;

   logic        use_model;
   logic        tbl_wait, tbl_rv;
   logic [31:0] tbl_rdata;

   logic [31:0] mem_arr [0:1023];
   int          stall_cfg;
   int          stall_cnt, rd_left, wr_total;
   logic [9:0]  rd_ptr;
   logic [1:0]  wr_beat;
   logic        mdl_wait, mdl_rv;
   logic [31:0] mdl_rdata;

   logic        rec_en;
   logic        grants[$];

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURSTLEN_WIDTH(2)) dut (
      .clock(clock), .reset(reset),
      .m0_addr(m0_addr), .m0_burst_len(m0_burst_len), .m0_rd(m0_rd), .m0_wr(m0_wr),
      .m0_wr_data(m0_wr_data), .m0_waitrequest(m0_waitrequest),
      .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
      .m1_addr(m1_addr), .m1_burst_len(m1_burst_len), .m1_rd(m1_rd), .m1_wr(m1_wr),
      .m1_wr_data(m1_wr_data), .m1_waitrequest(m1_waitrequest),
      .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
      .mem_addr(mem_addr), .mem_burst_len(mem_burst_len), .mem_wr_data(mem_wr_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_waitrequest(mem_waitrequest),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign mdl_wait        = (mem_rd | mem_wr) && (stall_cnt < stall_cfg);
   assign mem_waitrequest = use_model ? mdl_wait  : tbl_wait;
   assign mem_rd_valid    = use_model ? mdl_rv    : tbl_rv;
   assign mem_rd_data     = use_model ? mdl_rdata : tbl_rdata;

   // Sequential memory: word i holds i - 0xC0; first read beat the cycle after accept.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'(i) - 32'hC0;
         stall_cnt <= 0;
         rd_left   <= 0;
         rd_ptr    <= '0;
         wr_beat   <= '0;
         wr_total  <= 0;
         mdl_rv    <= 1'b0;
         mdl_rdata <= '0;
      end else if (use_model) begin
         if ((mem_rd | mem_wr) && mdl_wait) stall_cnt <= stall_cnt + 1;
         else                               stall_cnt <= 0;
         if (mem_rd && !mdl_wait) begin
            mdl_rv    <= 1'b1;
            mdl_rdata <= mem_arr[mem_addr[9:0]];
            rd_ptr    <= mem_addr[9:0] + 10'd1;
            rd_left   <= int'(mem_burst_len);
         end else if (rd_left > 0) begin
            mdl_rv    <= 1'b1;
            mdl_rdata <= mem_arr[rd_ptr];
            rd_ptr    <= rd_ptr + 10'd1;
            rd_left   <= rd_left - 1;
         end else begin
            mdl_rv    <= 1'b0;
            mdl_rdata <= '0;
         end
         if (mem_wr && !mdl_wait) begin
            mem_arr[mem_addr[9:0] + 10'(wr_beat)] <= mem_wr_data;
            wr_total <= wr_total + 1;
            if (wr_beat == mem_burst_len) wr_beat <= '0;
            else                          wr_beat <= wr_beat + 2'd1;
         end
      end
   end

   always @(negedge clock)
      if (rec_en && ((mem_rd | mem_wr) && !mem_waitrequest))
         grants.push_back(m0_waitrequest ? 1'b1 : 1'b0);

   typedef struct {
      logic [3:0]  req;    // {rd0, wr0, rd1, wr1}
      logic        mw, mrv;
      logic [31:0] mrdata;
      logic [5:0]  ctl;    // {w0, w1, rv0, rv1, mem_rd, mem_wr}
      logic [31:0] maddr, mwd, rdat0, rdat1;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mkv(input logic [3:0] req, input logic mw, input logic mrv,
                                input logic [31:0] mrdata, input logic [5:0] ctl,
                                input logic [31:0] maddr, input logic [31:0] mwd,
                                input logic [31:0] rdat0, input logic [31:0] rdat1);
      vec_t v;
      v.req = req; v.mw = mw; v.mrv = mrv; v.mrdata = mrdata; v.ctl = ctl;
      v.maddr = maddr; v.mwd = mwd; v.rdat0 = rdat0; v.rdat1 = rdat1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic wreq(input int m);
      return (m == 0) ? m0_waitrequest : m1_waitrequest;
   endfunction
   function automatic logic rvld(input int m);
      return (m == 0) ? m0_rd_valid : m1_rd_valid;
   endfunction
   function automatic logic [31:0] rdat(input int m);
      return (m == 0) ? m0_rd_data : m1_rd_data;
   endfunction

   task automatic set_cmd(input int m, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [1:0] bl, input logic [31:0] wd);
      if (m == 0) begin
         m0_rd = rd; m0_wr = wr; m0_addr = a; m0_burst_len = bl; m0_wr_data = wd;
      end else begin
         m1_rd = rd; m1_wr = wr; m1_addr = a; m1_burst_len = bl; m1_wr_data = wd;
      end
   endtask

   task automatic wait_accept(input int m, input string name, output int lat);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (wreq(m) && lat < 100);
      check(name, 32'(wreq(m)), 32'd0);
   endtask

   task automatic mread(input int m, input logic [31:0] a, input logic [1:0] bl, output int lat);
      int n, cyc;
      set_cmd(m, 1'b1, 1'b0, a, bl, '0);
      wait_accept(m, $sformatf("m%0d rd accept", m), lat);
      @(posedge clock); #1;
      set_cmd(m, 1'b0, 1'b0, a, bl, '0);
      n = 0; cyc = 0;
      while (n <= int'(bl) && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (rvld(m)) begin
            check($sformatf("m%0d rd beat %0d", m, n), rdat(m), a - 32'hC0 + 32'(n));
            check($sformatf("m%0d other rd_valid", m), 32'(rvld(1 - m)), 32'd0);
            n++;
         end
      end
      check($sformatf("m%0d rd beat count", m), 32'(n), 32'(bl) + 32'd1);
   endtask

   task automatic mwrite(input int m, input logic [31:0] a, input logic [1:0] bl,
                         input logic [31:0] d0, output int cyc);
      int k;
      k = 0; cyc = 0;
      set_cmd(m, 1'b0, 1'b1, a, bl, d0);
      while (k <= int'(bl) && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (!wreq(m)) begin
            @(posedge clock); #1;
            k++;
            if (k <= int'(bl)) set_cmd(m, 1'b0, 1'b1, a, bl, d0 + 32'(k));
            else               set_cmd(m, 1'b0, 1'b0, a, bl, '0);
         end
      end
      check($sformatf("m%0d wr beat count", m), 32'(k), 32'(bl) + 32'd1);
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, cyc, n, w0;
      logic [3:0] g;

      vecs[0]  = mkv(4'b0000, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[1]  = mkv(4'b1010, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[2]  = mkv(4'b1010, 0, 0, 32'h0,  6'b010010, 32'h100, 32'h0,  32'h0,  32'h0);
      vecs[3]  = mkv(4'b0010, 0, 1, 32'h55, 6'b111000, 32'h0,   32'h0,  32'h55, 32'h0);
      vecs[4]  = mkv(4'b0010, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[5]  = mkv(4'b1010, 1, 0, 32'h0,  6'b110010, 32'h200, 32'h0,  32'h0,  32'h0);
      vecs[6]  = mkv(4'b1010, 0, 0, 32'h0,  6'b100010, 32'h200, 32'h0,  32'h0,  32'h0);
      vecs[7]  = mkv(4'b1000, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[8]  = mkv(4'b1000, 0, 1, 32'h77, 6'b110100, 32'h0,   32'h0,  32'h0,  32'h77);
      vecs[9]  = mkv(4'b1001, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[10] = mkv(4'b1001, 0, 0, 32'h0,  6'b010010, 32'h100, 32'h0,  32'h0,  32'h0);
      vecs[11] = mkv(4'b0001, 0, 1, 32'h12, 6'b111000, 32'h0,   32'h0,  32'h12, 32'h0);
      vecs[12] = mkv(4'b1001, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[13] = mkv(4'b1001, 0, 0, 32'h0,  6'b100001, 32'h200, 32'hD1, 32'h0,  32'h0);
      vecs[14] = mkv(4'b0000, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[15] = mkv(4'b1100, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[16] = mkv(4'b1100, 0, 0, 32'h0,  6'b010010, 32'h100, 32'h0,  32'h0,  32'h0);
      vecs[17] = mkv(4'b0100, 0, 1, 32'h34, 6'b111000, 32'h0,   32'h0,  32'h34, 32'h0);
      vecs[18] = mkv(4'b0100, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);
      vecs[19] = mkv(4'b0100, 0, 0, 32'h0,  6'b010001, 32'h100, 32'hD0, 32'h0,  32'h0);
      vecs[20] = mkv(4'b0000, 0, 0, 32'h0,  6'b110000, 32'h0,   32'h0,  32'h0,  32'h0);

      use_model = 1'b0; stall_cfg = 0; rec_en = 1'b0;
      tbl_wait = 1'b0; tbl_rv = 1'b0; tbl_rdata = '0;
      set_cmd(0, 1'b0, 1'b0, 32'h100, 2'd0, 32'hD0);
      set_cmd(1, 1'b0, 1'b0, 32'h200, 2'd0, 32'hD1);
      reset = 1'b1;
      @(negedge clock);
      check("reset ctl", {26'b0, m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid,
                          mem_rd, mem_wr}, {26'b0, 6'b110000});
      check("reset mem_addr", mem_addr, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         {m0_rd, m0_wr, m1_rd, m1_wr} = vecs[i].req;
         tbl_wait  = vecs[i].mw;
         tbl_rv    = vecs[i].mrv;
         tbl_rdata = vecs[i].mrdata;
         @(negedge clock);
         check($sformatf("vec%0d ctl", i), {26'b0, m0_waitrequest, m1_waitrequest, m0_rd_valid,
                m1_rd_valid, mem_rd, mem_wr}, {26'b0, vecs[i].ctl});
         check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].maddr);
         check($sformatf("vec%0d mem_wr_data", i), mem_wr_data, vecs[i].mwd);
         check($sformatf("vec%0d m0_rd_data", i), m0_rd_data, vecs[i].rdat0);
         check($sformatf("vec%0d m1_rd_data", i), m1_rd_data, vecs[i].rdat1);
         @(posedge clock); #1;
      end

      // Memory-model phase
      use_model = 1'b1;
      set_cmd(0, 1'b0, 1'b0, '0, 2'd0, '0);
      set_cmd(1, 1'b0, 1'b0, '0, 2'd0, '0);
      reset_pulse();

      mread(0, 32'h100, 2'd3, lat);
      check("m0 rd latency", 32'(lat), 32'd2);
      @(negedge clock);
      check("m0 no extra beat", 32'(m0_rd_valid), 32'd0);
      @(posedge clock); #1;

      stall_cfg = 2;
      mwrite(1, 32'h200, 2'd3, 32'hA0, cyc);
      check("m1 stalled wr cycles", 32'(cyc), 32'd13);
      @(negedge clock);
      check("wr done idle mem_wr", 32'(mem_wr), 32'd0);
      check("wr done idle wait", 32'(m1_waitrequest), 32'd1);
      for (int k = 0; k < 4; k++)
         check($sformatf("mem[0x%0h]", 32'h200 + k), mem_arr[10'h200 + 10'(k)], 32'hA0 + 32'(k));
      stall_cfg = 0;
      @(posedge clock); #1;

      // Continuous requests from both masters alternate grants
      reset_pulse();
      grants.delete();
      rec_en = 1'b1;
      fork
         begin
            int l0;
            mread(0, 32'h100, 2'd3, l0);
            mread(0, 32'h100, 2'd3, l0);
         end
         begin
            int l1;
            mread(1, 32'h300, 2'd3, l1);
            mread(1, 32'h300, 2'd3, l1);
         end
      join
      rec_en = 1'b0;
      check("grant count", 32'(grants.size()), 32'd4);
      g = 4'hF;
      if (grants.size() == 4) g = {grants[0], grants[1], grants[2], grants[3]};
      check("grant order", {28'b0, g}, {28'b0, 4'b0101});
      @(posedge clock); #1;

      // rd and wr together: read first, write as its own transaction
      set_cmd(0, 1'b1, 1'b1, 32'h180, 2'd0, 32'h5A);
      wait_accept(0, "rdwr read accept", lat);
      check("rdwr mem_rd", 32'(mem_rd), 32'd1);
      check("rdwr mem_wr during read", 32'(mem_wr), 32'd0);
      @(posedge clock); #1;
      set_cmd(0, 1'b0, 1'b1, 32'h180, 2'd0, 32'h5A);
      cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (!m0_rd_valid && cyc < 50);
      check("rdwr rd_valid", 32'(m0_rd_valid), 32'd1);
      check("rdwr rd data", m0_rd_data, 32'hC0);
      wait_accept(0, "rdwr write accept", lat);
      check("rdwr mem_wr", 32'(mem_wr), 32'd1);
      check("rdwr mem_wr_data", mem_wr_data, 32'h5A);
      @(posedge clock); #1;
      set_cmd(0, 1'b0, 1'b0, '0, 2'd0, '0);
      @(negedge clock);
      check("rdwr mem written", mem_arr[10'h180], 32'h5A);
      @(posedge clock); #1;

      // Single-beat read then a 4-beat write from the same master
      mread(0, 32'h140, 2'd0, lat);
      w0 = wr_total;
      mwrite(0, 32'h140, 2'd3, 32'hB0, cyc);
      check("bl3 wr cycles", 32'(cyc), 32'd5);
      @(negedge clock);
      check("bl3 wr beats at memory", 32'(wr_total - w0), 32'd4);
      for (int k = 0; k < 4; k++)
         check($sformatf("mem[0x%0h]", 32'h140 + k), mem_arr[10'h140 + 10'(k)], 32'hB0 + 32'(k));
      @(posedge clock); #1;

      // Reset in the middle of a 4-beat read
      set_cmd(0, 1'b1, 1'b0, 32'h100, 2'd3, '0);
      wait_accept(0, "abort rd accept", lat);
      @(posedge clock); #1;
      set_cmd(0, 1'b0, 1'b0, 32'h100, 2'd3, '0);
      n = 0; cyc = 0;
      while (n < 2 && cyc < 50) begin
         @(negedge clock);
         cyc++;
         if (m0_rd_valid) n++;
      end
      check("abort beats before reset", 32'(n), 32'd2);
      #1 reset = 1'b1;
      #1;
      check("abort ctl", {26'b0, m0_waitrequest, m1_waitrequest, m0_rd_valid, m1_rd_valid,
                          mem_rd, mem_wr}, {26'b0, 6'b110000});
      check("abort m0_rd_data", m0_rd_data, 32'h0);
      check("abort mem_addr", mem_addr, 32'h0);
      check("abort mem_burst_len", {30'b0, mem_burst_len}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      mread(1, 32'h300, 2'd3, lat);
      check("post-reset m1 latency", 32'(lat), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
